// File: rtl/lif_pkg.sv
// lif_pkg: shared types and helpers for the time-multiplexed LIF layer.
//   state_e  - sweep FSM state encoding
//   sat_add  - unsigned add clamped to 2^w-1 (w <= 32)
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Unsigned add of two w-bit values, clamped to the w-bit maximum.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// lif_update: combinational single-neuron leak/integrate/fire datapath.
//   u, acc    - current membrane and accumulated input current
//   u_next    - membrane after this timestep
//   fire      - neuron spikes this timestep
//   rc/rc_next- refractory counter, present only with LIF_REFRACTORY_EN
module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DECAY_SHIFT  = 1,
    parameter int unsigned THRESHOLD    = 32,
    parameter int unsigned REFRAC_STEPS = 2,
    parameter int unsigned RCW          = 2
) (
    input  logic [WIDTH-1:0] u,
    input  logic [WIDTH-1:0] acc,
`ifdef LIF_REFRACTORY_EN
    input  logic [RCW-1:0]   rc,
    output logic [RCW-1:0]   rc_next,
`endif
    output logic [WIDTH-1:0] u_next,
    output logic             fire
);

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    // Elaboration-time parameter sanity.
    if (THRESHOLD >= (64'd1 << WIDTH) || REFRAC_STEPS > 65535 || RCW == 0) begin : g_bad_param
        $error("lif_update: THRESHOLD/REFRAC_STEPS out of range");
    end

    logic [WIDTH-1:0] v;

    always_comb begin
        // Leak then integrate; the add is carried at 33 bits and clamped.
        v      = WIDTH'(sat_add(32'(u >> DECAY_SHIFT), 32'(acc), WIDTH));
        fire   = (v >= THR);
        u_next = fire ? '0 : v;
`ifdef LIF_REFRACTORY_EN
        rc_next = fire ? RCW'(REFRAC_STEPS) : '0;
        // A refractory neuron is clamped at rest and cannot fire.
        if (rc != '0) begin
            u_next  = '0;
            fire    = 1'b0;
            rc_next = rc - RCW'(1);
        end
`endif
    end

endmodule

// File: rtl/lif_layer.sv
// lif_layer: N_NEURONS leaky integrate-and-fire neurons sharing one update
// datapath. Events accumulate per neuron while idle; a tick sweeps all
// neurons in index order and emits spikes on a valid/ready port.
//   in_valid/in_ready/in_idx/in_current - input current events
//   tick                                - timestep strobe
//   spike_valid/spike_ready/spike_idx   - output spike events
//   step_done                           - pulse when a sweep finishes
//   overrun                             - pulse when a tick arrives mid-sweep
// Optional: define LIF_REFRACTORY_EN to build per-neuron refractory counters.
module lif_layer
    import lif_pkg::*;
#(
    parameter  int unsigned N_NEURONS    = 16,
    parameter  int unsigned WIDTH        = 8,
    parameter  int unsigned DECAY_SHIFT  = 1,
    parameter  int unsigned THRESHOLD    = 32,
    parameter  int unsigned REFRAC_STEPS = 2,
    localparam int unsigned IDXW         = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDXW-1:0]  in_idx,
    input  logic [WIDTH-1:0] in_current,
    input  logic             tick,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [IDXW-1:0]  spike_idx,
    output logic             step_done,
    output logic             overrun
);

    localparam int unsigned RCW = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);

    if (N_NEURONS < 2 || DECAY_SHIFT >= WIDTH) begin : g_bad_param
        $error("lif_layer: N_NEURONS/DECAY_SHIFT out of range");
    end

    state_e           state_q, state_d;
    logic [IDXW-1:0]  sweep_idx_q, sweep_idx_d;
    logic [WIDTH-1:0] u_q   [N_NEURONS];
    logic [WIDTH-1:0] u_d   [N_NEURONS];
    logic [WIDTH-1:0] acc_q [N_NEURONS];
    logic [WIDTH-1:0] acc_d [N_NEURONS];
    logic             in_ready_q, in_ready_d;
    logic             spike_valid_q, spike_valid_d;
    logic [IDXW-1:0]  spike_idx_q, spike_idx_d;
    logic             step_done_q, step_done_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] upd_u_next;
    logic             upd_fire;

`ifdef LIF_REFRACTORY_EN
    logic [RCW-1:0]   rc_q [N_NEURONS];
    logic [RCW-1:0]   rc_d [N_NEURONS];
    logic [RCW-1:0]   upd_rc_next;
`endif

    // Shared neuron datapath, always looking at the neuron under the sweep pointer.
    lif_update #(
        .WIDTH        (WIDTH),
        .DECAY_SHIFT  (DECAY_SHIFT),
        .THRESHOLD    (THRESHOLD),
        .REFRAC_STEPS (REFRAC_STEPS),
        .RCW          (RCW)
    ) u_update (
        .u       (u_q[sweep_idx_q]),
        .acc     (acc_q[sweep_idx_q]),
`ifdef LIF_REFRACTORY_EN
        .rc      (rc_q[sweep_idx_q]),
        .rc_next (upd_rc_next),
`endif
        .u_next  (upd_u_next),
        .fire    (upd_fire)
    );

    // Next-state, storage update and output register logic.
    always_comb begin
        state_d       = state_q;
        sweep_idx_d   = sweep_idx_q;
        u_d           = u_q;
        acc_d         = acc_q;
`ifdef LIF_REFRACTORY_EN
        rc_d          = rc_q;
`endif
        in_ready_d    = in_ready_q;
        spike_valid_d = spike_valid_q;
        spike_idx_d   = spike_idx_q;
        step_done_d   = 1'b0;
        overrun_d     = tick && (state_q != ST_IDLE);

        // Output register drains whenever downstream accepts.
        if (spike_valid_q && spike_ready) begin
            spike_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q && (32'(in_idx) < N_NEURONS)) begin
                    acc_d[in_idx] = WIDTH'(sat_add(32'(acc_q[in_idx]), 32'(in_current), WIDTH));
                end
                if (tick) begin
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                    in_ready_d  = 1'b0;
                end
            end
            ST_SWEEP: begin
                // A pending spike that is not being taken blocks the sweep.
                if (!(spike_valid_q && !spike_ready)) begin
                    u_d[sweep_idx_q]   = upd_u_next;
                    acc_d[sweep_idx_q] = '0;
`ifdef LIF_REFRACTORY_EN
                    rc_d[sweep_idx_q]  = upd_rc_next;
`endif
                    if (upd_fire) begin
                        spike_valid_d = 1'b1;
                        spike_idx_d   = sweep_idx_q;
                    end
                    if (sweep_idx_q == IDXW'(N_NEURONS - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        sweep_idx_d = sweep_idx_q + IDXW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // in_ready comes back one cycle after step_done via the IDLE branch.
                if (!spike_valid_q || spike_ready) begin
                    step_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sweep_idx_q   <= '0;
            u_q           <= '{default: '0};
            acc_q         <= '{default: '0};
`ifdef LIF_REFRACTORY_EN
            rc_q          <= '{default: '0};
`endif
            in_ready_q    <= 1'b1;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            step_done_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_idx_q   <= sweep_idx_d;
            u_q           <= u_d;
            acc_q         <= acc_d;
`ifdef LIF_REFRACTORY_EN
            rc_q          <= rc_d;
`endif
            in_ready_q    <= in_ready_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            step_done_q   <= step_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign step_done   = step_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_lif_layer.sv
// tb_lif_layer: directed self-checking bench for lif_layer at default parameters.
// Expectations follow LIF_REFRACTORY_EN when it is defined for the build.
module tb_lif_layer;

    localparam int unsigned N    = 16;
    localparam int unsigned W    = 8;
    localparam int unsigned IDXW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IDXW-1:0] in_idx = '0;
    logic [W-1:0]    in_current = '0;
    logic            tick = 1'b0;
    logic            spike_valid;
    logic            spike_ready = 1'b1;
    logic [IDXW-1:0] spike_idx;
    logic            step_done;
    logic            overrun;

    int total = 0;
    int bad   = 0;
    int spk_q[$];

    lif_layer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_idx      (in_idx),
        .in_current  (in_current),
        .tick        (tick),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_idx   (spike_idx),
        .step_done   (step_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Log every spike handshake in arrival order.
    always @(posedge clk) begin
        if (!rst && spike_valid && spike_ready) spk_q.push_back(int'(spike_idx));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; tick = 1'b0; spike_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        spk_q.delete();
    endtask

    task automatic send(input int idx, input int cur);
        int n = 0;
        while (!in_ready && n < 50) begin cyc(); n++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL send_ready: in_ready=%0b want 1", in_ready);
        end
        in_valid = 1'b1; in_idx = IDXW'(idx); in_current = W'(cur);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (step_done !== 1'b1 && cycles < budget) begin cyc(); cycles++; end
    endtask

    task automatic test_reset();
        int c;
        repeat (2) cyc();
        total++;
        if ({spike_valid, step_done, overrun} !== 3'b000) begin
            bad++; $display("FAIL reset_hold: sv/sd/ov=%b want 000", {spike_valid, step_done, overrun});
        end
        rst = 1'b0;
        cyc();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        // Mid-sweep reset with a stalled spike in the output register.
        send(3, 40);
        spike_ready = 1'b0;
        do_tick();
        repeat (6) cyc();
        total++;
        if (spike_valid !== 1'b1) begin bad++; $display("FAIL reset_pre_spike: got %0b want 1", spike_valid); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({spike_valid, step_done, overrun} !== 3'b000 || spike_idx !== '0) begin
            bad++; $display("FAIL reset_async: sv/sd/ov=%b idx=%0d want 000 idx 0",
                            {spike_valid, step_done, overrun}, spike_idx);
        end
        spike_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
        spk_q.delete();
        do_tick();
        wait_done(60, c);
        total++;
        if (c !== 17) begin bad++; $display("FAIL reset_sweep_done: cycles=%0d want 17", c); end
        total++;
        if (spk_q.size() !== 0) begin bad++; $display("FAIL reset_no_spike: spikes=%0d want 0", spk_q.size()); end
    endtask

    task automatic test_single_fire();
        int c;
        do_reset();
        send(3, 40);
        spk_q.delete();
        do_tick();
        wait_done(60, c);
        total++;
        if (c !== 17) begin bad++; $display("FAIL single_done: cycles=%0d want 17", c); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL single_ready_at_done: got %0b want 0", in_ready); end
        total++;
        if (spk_q.size() !== 1 || spk_q[0] !== 3) begin
            bad++; $display("FAIL single_spike: n=%0d first=%0d want n=1 idx=3",
                            spk_q.size(), (spk_q.size() > 0) ? spk_q[0] : -1);
        end
        cyc();
        total++;
        if ({in_ready, step_done} !== 2'b10) begin
            bad++; $display("FAIL single_after_done: ready/done=%b want 10", {in_ready, step_done});
        end
        spk_q.delete();
        do_tick();
        wait_done(60, c);
        total++;
        if (spk_q.size() !== 0) begin bad++; $display("FAIL single_empty_tick: spikes=%0d want 0", spk_q.size()); end
    endtask

    task automatic test_leak();
        int c;
        int exp_n [3] = '{0, 0, 1};
        do_reset();
        for (int t = 0; t < 3; t++) begin
            send(5, 20);
            spk_q.delete();
            do_tick();
            wait_done(60, c);
            total++;
            if (spk_q.size() !== exp_n[t] || (exp_n[t] == 1 && spk_q[0] !== 5)) begin
                bad++; $display("FAIL leak_tick%0d: spikes=%0d first=%0d want %0d at idx 5",
                                t, spk_q.size(), (spk_q.size() > 0) ? spk_q[0] : -1, exp_n[t]);
            end
        end
    endtask

    task automatic test_saturation();
        int c;
        do_reset();
        // Accumulator clamp: 4 x 200 -> 255.
        for (int i = 0; i < 4; i++) send(0, 200);
        spk_q.delete(); do_tick(); wait_done(60, c);
        total++;
        if (spk_q.size() !== 1 || spk_q[0] !== 0) begin
            bad++; $display("FAIL sat_acc4: spikes=%0d want 1 at idx 0", spk_q.size());
        end
        // 200+70 would wrap to 14 (no fire); clamped 255 fires.
        send(0, 200); send(0, 70);
        spk_q.delete(); do_tick(); wait_done(60, c);
        total++;
        if (spk_q.size() !== 1 || spk_q[0] !== 0) begin
            bad++; $display("FAIL sat_acc_wrap: spikes=%0d want 1 at idx 0", spk_q.size());
        end
        // Membrane clamp: u=31 -> 15+250 = 265 -> 255 (a wrap would give 9).
        send(4, 31);
        spk_q.delete(); do_tick(); wait_done(60, c);
        total++;
        if (spk_q.size() !== 0) begin bad++; $display("FAIL sat_u_prime: spikes=%0d want 0", spk_q.size()); end
        send(4, 250);
        spk_q.delete(); do_tick(); wait_done(60, c);
        total++;
        if (spk_q.size() !== 1 || spk_q[0] !== 4) begin
            bad++; $display("FAIL sat_v: spikes=%0d want 1 at idx 4", spk_q.size());
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        send(2, 40); send(7, 40);
        spk_q.delete();
        do_tick();
        while (!spike_valid && c < 40) begin cyc(); c++; end
        total++;
        if (c !== 3) begin bad++; $display("FAIL bp_first_spike: cycle=%0d want 3", c); end
        spike_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); c++;
            total++;
            if ({spike_valid, in_ready} !== 2'b10 || spike_idx !== 2) begin
                bad++; $display("FAIL bp_stall%0d: sv/ready=%b idx=%0d want 10 idx 2",
                                i, {spike_valid, in_ready}, spike_idx);
            end
        end
        spike_ready = 1'b1;
        while (step_done !== 1'b1 && c < 80) begin
            cyc(); c++;
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: cycle=%0d in_ready=%0b want 0", c, in_ready); end
        end
        total++;
        if (c !== 22) begin bad++; $display("FAIL bp_done: cycles=%0d want 22", c); end
        total++;
        if (spk_q.size() !== 2 || spk_q[0] !== 2 || spk_q[1] !== 7) begin
            bad++; $display("FAIL bp_order: n=%0d want 2 spikes 2 then 7", spk_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        // Event and tick in the same cycle: the event is included in the sweep.
        in_valid = 1'b1; in_idx = 4'd6; in_current = 8'd50; tick = 1'b1;
        spk_q.delete();
        cyc();
        in_valid = 1'b0; tick = 1'b0;
        wait_done(60, c);
        total++;
        if (c !== 17) begin bad++; $display("FAIL b2b_done: cycles=%0d want 17", c); end
        total++;
        if (spk_q.size() !== 1 || spk_q[0] !== 6) begin
            bad++; $display("FAIL b2b_spike: spikes=%0d want 1 at idx 6", spk_q.size());
        end
    endtask

    task automatic test_refractory_overrun();
        int c;
        int extra;
`ifdef LIF_REFRACTORY_EN
        int exp_n [5] = '{1, 0, 0, 1, 0};
`else
        int exp_n [5] = '{1, 1, 1, 1, 1};
`endif
        do_reset();
        for (int t = 0; t < 5; t++) begin
            send(1, 100);
            spk_q.delete();
            do_tick();
            if (t == 1) begin
                repeat (3) cyc();
                tick = 1'b1;
                cyc();
                tick = 1'b0;
                total++;
                if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %0b want 1", overrun); end
                cyc();
                total++;
                if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_single: got %0b want 0", overrun); end
                wait_done(60, c);
                c = c + 5;
            end else begin
                wait_done(60, c);
            end
            total++;
            if (c !== 17) begin bad++; $display("FAIL refr_done%0d: cycles=%0d want 17", t, c); end
            total++;
            if (spk_q.size() !== exp_n[t]) begin
                bad++; $display("FAIL refr_tick%0d: spikes=%0d want %0d", t, spk_q.size(), exp_n[t]);
            end
            if (t == 1) begin
                // The dropped tick must not start another sweep.
                extra = 0;
                cyc();
                for (int i = 0; i < 20; i++) begin
                    if (step_done || !in_ready) extra++;
                    cyc();
                end
                total++;
                if (extra !== 0) begin bad++; $display("FAIL ovr_no_sweep: busy cycles=%0d want 0", extra); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_leak();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_refractory_overrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lif_layer.md
# lif_layer

Time-multiplexed layer of `N_NEURONS` leaky integrate-and-fire neurons with one shared update datapath. It is the parametrised successor of our single-neuron LIF cell, sized for sparse, event-driven input. Input spikes and currents arrive as indexed events and are accumulated per neuron. A `tick` pulse starts a timestep sweep that applies leak and integration and performs the threshold test on each neuron in turn. Output spikes leave as indexed events on a valid/ready port toward the next layer or the spike encoder.

## Interface
- `N_NEURONS`, 16: neuron count, at least 2; `IDXW = $clog2(N_NEURONS)`.
- `WIDTH`, 8: membrane and current width, unsigned.
- `DECAY_SHIFT`, 1: leak factor beta = 2^-DECAY_SHIFT, 0 ≤ DECAY_SHIFT < WIDTH.
- `THRESHOLD`, 32: firing threshold, must be below 2^WIDTH.
- `REFRAC_STEPS`, 2: refractory timesteps after a spike (used only with `LIF_REFRACTORY_EN`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input event valid.
- `in_ready`  out  1  event accepted when `in_valid && in_ready`.
- `in_idx`  in  IDXW  target neuron.
- `in_current`  in  WIDTH  current to add.
- `tick`  in  1  single-cycle timestep strobe.
- `spike_valid`  out  1  output spike event valid.
- `spike_ready`  in  1  downstream accept.
- `spike_idx`  out  IDXW  index of the firing neuron.
- `step_done`  out  1  one-cycle pulse when the sweep completes.
- `overrun`  out  1  one-cycle pulse when a `tick` arrives while the block is not IDLE.

## Operation
- Per-neuron storage: membrane `u[i]` and accumulator `acc[i]`, both WIDTH bits. With the macro enabled, also a refractory counter `rc[i]`.
- FSM states: IDLE, SWEEP, DRAIN.
- **IDLE**
  - `in_ready` = 1.
  - On an accepted event, `acc[in_idx]` becomes `sat(acc[in_idx] + in_current)`, saturating at 2^WIDTH-1.
  - An event with `in_idx ≥ N_NEURONS` is accepted and discarded.
  - On `tick`, `sweep_idx` is set to 0 and the FSM goes to SWEEP. A tick and an event in the same cycle: the event is applied first.
- **SWEEP**
  - `in_ready` = 0.
  - Each unstalled cycle processes neuron `sweep_idx`:
    - `v = sat((u >> DECAY_SHIFT) + acc)`, computed at WIDTH+1 bits and then saturated.
    - `acc` is cleared.
    - If `v ≥ THRESHOLD`, the neuron fires: `u` becomes 0 and a spike is loaded into the output register (`spike_valid`=1, `spike_idx`=i). Otherwise `u` becomes `v`.
  - Stall condition: `spike_valid && !spike_ready`. While stalled, no neuron is processed.
  - After neuron N_NEURONS-1 is processed, the FSM goes to DRAIN.
- **DRAIN**
  - Waits until the output register is empty, or is being accepted this cycle.
  - Then pulses `step_done` and returns to IDLE.
- A `tick` outside IDLE is dropped and pulses `overrun`.
- Reset, asynchronous at any point including mid-sweep:
  - All `u`, `acc` and `rc` = 0.
  - FSM = IDLE.
  - `spike_valid`, `spike_idx`, `step_done`, `overrun` = 0.
  - `in_ready` = 1 from the first cycle after reset deasserts.

## Timing
- Tick sampled at edge k: neuron i is processed at edge k+1+i plus accumulated stall cycles.
- `spike_valid` is registered and appears the cycle after its neuron is processed.
- Without backpressure, `step_done` is high in cycle k+N_NEURONS+1.
- Throughput: one neuron per cycle; a spike accepted in the same cycle it is shown causes no stall.
- Spikes are emitted in ascending index order.
- `in_ready` drops in the cycle after a tick is sampled and rises in the cycle after `step_done`.

## Configuration
- `LIF_REFRACTORY_EN` defined:
  - On a spike, `rc[i]` is set to REFRAC_STEPS.
  - In each later sweep with `rc[i] > 0`: `u` is held at 0, `acc` is cleared, no spike is produced, and `rc[i]` is decremented.
- `LIF_REFRACTORY_EN` undefined: no `rc` storage is built, `REFRAC_STEPS` is ignored, and a neuron may fire in every timestep.

## Structure
- Package `lif_pkg`:
  - FSM state enum.
  - Saturating-add function.
- Sub-module `lif_update`: combinational single-neuron datapath.
  - Inputs: `u`, `acc`, `rc`.
  - Outputs: `u_next`, `rc_next`, `fire`.
  - Parameters: WIDTH, DECAY_SHIFT, THRESHOLD, REFRAC_STEPS.
- `lif_layer` contains the storage arrays, the FSM, the handshake logic and the output register.

## Test plan
All scenarios use defaults: N=16, WIDTH=8, shift 1, threshold 32, `spike_ready`=1 unless stated.
- Reset: assert `rst` mid-sweep → all outputs 0 immediately; after release, `in_ready`=1 and the next sweep with no input produces no spikes.
- Single fire: event idx 3, current 40, then tick → exactly one spike with `spike_idx`=3; `step_done` at k+17; next empty tick gives no spike (u3=0).
- Leak: idx 5 gets 20, 20, 20 across three ticks → u = 20, 30, then 35 fires on the third tick only.
- Saturation: four events of 200 to idx 0, then tick → acc=255, v=255, spike on idx 0, no wrap.
- Backpressure: spikes on idx 2 and 7, `spike_ready` held low 5 cycles when the first spike appears → order 2 then 7; `step_done` 5 cycles late; `in_ready` stays 0 throughout.
- Refractory, overrun:
  - Idx 1 receives 100 before every tick.
  - With the macro: spikes on ticks 1 and 4 only.
  - Without the macro: spikes on every tick.
  - A tick during any sweep → `overrun` pulse, no extra sweep.
